fetch_queue_unit: RTL and testbench

//  Instruction-fetch front end for the pipelined datapath. It owns the PC, issues sequential

---
 rtl/cpu_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/fetch_queue_unit.sv | 82 ++++++++
 tb/tb_fetch_queue_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared widths and payload types for the instruction-fetch front end.
package cpu_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 64;

    localparam logic [ADDR_W-1:0] PC_STEP = 64'd4;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries; flush outranks push/pop.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fetch_entry_t,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  entry_t           push_data,
    output logic [CNT_W-1:0] count,
    output entry_t           head
);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Head is registered storage read directly, never bypassed from push_data.
    assign head = mem[rd_ptr];

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && !flush && (count == CNT_W'(DEPTH))));

    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && !flush && (count == '0)));

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch front end: owns the PC, issues sequential imem requests with credit
// accounting, and queues {pc, instr} pairs for decode; redirects flush everything.
module fetch_queue_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'd0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] cap_pc_q;
    logic              inflight_q;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    credits_used;
    logic [ADDR_W-1:0] redirect_aligned;
    logic              push;
    logic              pop;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    // Buffered entries plus the one outstanding response must fit in the FIFO.
    assign credits_used     = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_q);
    assign redirect_aligned = redirect_pc & ~ADDR_W'(3);

    assign imem_req  = !reset && !redirect_valid && (credits_used < (CNT_W + 1)'(DEPTH));
    assign imem_addr = imem_req ? pc_q : '0;

    assign out_valid = (fifo_count != '0) && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign push      = inflight_q && !redirect_valid;

    assign push_entry = '{pc: cap_pc_q, instr: imem_rdata};
    assign out_pc     = head_entry.pc;
    assign out_instr  = head_entry.instr;

    // PC, in-flight flag and the pc captured for the pending response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            cap_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else if (redirect_valid) begin
            pc_q       <= redirect_aligned;
            inflight_q <= 1'b0;
        end else if (imem_req) begin
            pc_q       <= pc_q + PC_STEP;
            cap_pc_q   <= pc_q;
            inflight_q <= 1'b1;
        end else begin
            inflight_q <= 1'b0;
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_data (push_entry),
        .count     (fifo_count),
        .head      (head_entry)
    );

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed scenarios plus randomized traffic checked
// against a queue-based model of the fetch stream.
module tb_fetch_queue_unit;
    import cpu_pkg::*;

    localparam int unsigned DEPTH    = 4;
    localparam logic [63:0] RST_PC_B = 64'h40;
    localparam logic [31:0] IMASK    = 32'hA5A5_0000;

    logic        clk            = 1'b0;
    logic        reset          = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc    = '0;
    logic        out_ready      = 1'b1;
    logic        imem_req, out_valid;
    logic [63:0] imem_addr, out_pc;
    logic [31:0] imem_rdata, out_instr;

    logic        redir_b    = 1'b0;
    logic [63:0] redir_pc_b = '0;
    logic        ready_b    = 1'b1;
    logic        imem_req_b, out_valid_b;
    logic [63:0] imem_addr_b, out_pc_b;
    logic [31:0] imem_rdata_b, out_instr_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // One-cycle-latency instruction memory: instr = addr[31:0] ^ A5A5_0000.
    always @(posedge clk) imem_rdata   <= imem_addr[31:0] ^ IMASK;
    always @(posedge clk) imem_rdata_b <= imem_addr_b[31:0] ^ IMASK;

    fetch_queue_unit #(.DEPTH(DEPTH), .RESET_PC(64'd0)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
    );

    fetch_queue_unit #(.DEPTH(DEPTH), .RESET_PC(RST_PC_B)) dut_b (
        .clk(clk), .reset(reset), .imem_req(imem_req_b), .imem_addr(imem_addr_b),
        .imem_rdata(imem_rdata_b), .redirect_valid(redir_b), .redirect_pc(redir_pc_b),
        .out_valid(out_valid_b), .out_ready(ready_b), .out_pc(out_pc_b), .out_instr(out_instr_b)
    );

    // Reference model: queue of buffered pcs, one optional outstanding fetch, next pc.
    logic [63:0] mq[$];
    bit          m_infl;
    logic [63:0] m_infl_pc;
    logic [63:0] m_pc;

    function automatic logic [31:0] m_instr(input logic [63:0] pc);
        return pc[31:0] ^ IMASK;
    endfunction

    function automatic bit m_req();
        return !reset && !redirect_valid && ((mq.size() + int'(m_infl)) < int'(DEPTH));
    endfunction

    function automatic bit m_valid();
        return !reset && !redirect_valid && (mq.size() != 0);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_infl    = 1'b0;
        m_infl_pc = '0;
        m_pc      = '0;
    endtask

    task automatic model_edge();
        bit req, pop;
        if (reset) begin
            model_reset();
            return;
        end
        req = m_req();
        pop = m_valid() && out_ready;
        if (redirect_valid) begin
            mq.delete();
            m_infl = 1'b0;
            m_pc   = redirect_pc & ~64'd3;
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_infl) mq.push_back(m_infl_pc);
            if (req) begin
                m_infl_pc = m_pc;
                m_infl    = 1'b1;
                m_pc      = m_pc + 64'd4;
            end else begin
                m_infl = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        #2;
        n_cmp++;
        if (out_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 64'd0 ||
            out_pc !== 64'd0 || out_instr !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_state: valid=%b req=%b addr=%h pc=%h instr=%h, required all zero",
                     out_valid, imem_req, imem_addr, out_pc, out_instr);
        end
        n_cmp++;
        if (out_valid_b !== 1'b0 || imem_req_b !== 1'b0 || imem_addr_b !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_state_b: valid=%b req=%b addr=%h, required all zero",
                     out_valid_b, imem_req_b, imem_addr_b);
        end
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic test_steady();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_cmp++;
            if (imem_req !== 1'b1 || imem_addr !== 64'(4 * k) || out_valid !== (k >= 2)) begin
                n_bad++;
                $display("FAIL steady_issue k=%0d: req=%b addr=%h valid=%b, required req=1 addr=%h valid=%b",
                         k, imem_req, imem_addr, out_valid, 64'(4 * k), (k >= 2));
            end
            if (k >= 2) begin
                n_cmp++;
                if (out_pc !== 64'(4 * (k - 2)) || out_instr !== m_instr(64'(4 * (k - 2))) ||
                    out_pc_b !== RST_PC_B + 64'(4 * (k - 2))) begin
                    n_bad++;
                    $display("FAIL steady_data k=%0d: pc=%h instr=%h pc_b=%h, required pc=%h instr=%h pc_b=%h",
                             k, out_pc, out_instr, out_pc_b, 64'(4 * (k - 2)),
                             m_instr(64'(4 * (k - 2))), RST_PC_B + 64'(4 * (k - 2)));
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] base;
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            n_cmp++;
            if (out_valid !== m_valid() || imem_req !== m_req()) begin
                n_bad++;
                $display("FAIL bp_fill k=%0d: valid=%b req=%b, required valid=%b req=%b",
                         k, out_valid, imem_req, m_valid(), m_req());
            end
            tick();
        end
        #1;
        n_cmp++;
        if (dut.fifo_count !== 3'd4 || imem_req !== 1'b0 || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_full: count=%0d req=%b valid=%b, required count=4 req=0 valid=1",
                     dut.fifo_count, imem_req, out_valid);
        end
        base = mq[0];
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_cmp++;
            if (out_valid !== 1'b1 || out_pc !== base + 64'(4 * i) ||
                out_instr !== m_instr(base + 64'(4 * i))) begin
                n_bad++;
                $display("FAIL bp_drain i=%0d: valid=%b pc=%h instr=%h, required valid=1 pc=%h instr=%h",
                         i, out_valid, out_pc, out_instr, base + 64'(4 * i), m_instr(base + 64'(4 * i)));
            end
            tick();
        end
    endtask

    task automatic test_redirect(input logic [63:0] target, input bit double);
        logic [63:0] exp_pc;
        bit reached = 1'b0;
        exp_pc    = target & ~64'd3;
        out_ready = 1'b0;
        for (int k = 0; k < 16 && !reached; k++) begin
            #1;
            n_cmp++;
            if (out_valid !== m_valid() || imem_req !== m_req()) begin
                n_bad++;
                $display("FAIL redir_setup k=%0d: valid=%b req=%b, required valid=%b req=%b",
                         k, out_valid, imem_req, m_valid(), m_req());
            end
            if (mq.size() == 3 && m_infl) reached = 1'b1;
            else tick();
        end
        n_cmp++;
        if (!reached || dut.fifo_count !== 3'd3) begin
            n_bad++;
            $display("FAIL redir_setup_state: count=%0d reached=%b, required count=3 reached=1",
                     dut.fifo_count, reached);
        end
        out_ready = 1'b1;
        if (double) begin
            redirect_valid = 1'b1;
            redirect_pc    = 64'h0000_0000_0000_0ff0;
            tick();
        end
        redirect_valid = 1'b1;
        redirect_pc    = target;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || imem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL redir_pulse: valid=%b req=%b, required valid=0 req=0", out_valid, imem_req);
        end
        tick();
        redirect_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            #1;
            n_cmp++;
            if (out_valid !== (k >= 3) || (k == 1 && (imem_req !== 1'b1 || imem_addr !== exp_pc))) begin
                n_bad++;
                $display("FAIL redir_after k=%0d: valid=%b req=%b addr=%h, required valid=%b addr=%h",
                         k, out_valid, imem_req, imem_addr, (k >= 3), exp_pc);
            end
            if (k >= 3) begin
                n_cmp++;
                if (out_pc !== exp_pc + 64'(4 * (k - 3)) || out_instr !== m_instr(exp_pc + 64'(4 * (k - 3)))) begin
                    n_bad++;
                    $display("FAIL redir_data k=%0d: pc=%h instr=%h, required pc=%h instr=%h",
                             k, out_pc, out_instr, exp_pc + 64'(4 * (k - 3)),
                             m_instr(exp_pc + 64'(4 * (k - 3))));
                end
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        repeat (3) tick();
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || imem_req !== 1'b0 || out_valid_b !== 1'b0 || imem_req_b !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: valid=%b req=%b valid_b=%b req_b=%b, required all 0",
                     out_valid, imem_req, out_valid_b, imem_req_b);
        end
        repeat (2) tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++;
            if (out_valid !== (k >= 2) || out_valid_b !== (k >= 2) ||
                (k >= 2 && (out_pc !== 64'(4 * (k - 2)) || out_pc_b !== RST_PC_B + 64'(4 * (k - 2)) ||
                            out_instr_b !== m_instr(RST_PC_B + 64'(4 * (k - 2)))))) begin
                n_bad++;
                $display("FAIL restart k=%0d: valid=%b pc=%h valid_b=%b pc_b=%h, required valid=%b pc=%h pc_b=%h",
                         k, out_valid, out_pc, out_valid_b, out_pc_b, (k >= 2),
                         64'(4 * (k - 2)), RST_PC_B + 64'(4 * (k - 2)));
            end
            tick();
        end
    endtask

    task automatic test_full_pop();
        logic [63:0] base;
        out_ready = 1'b0;
        for (int k = 0; k < 16 && mq.size() < DEPTH; k++) tick();
        #1;
        n_cmp++;
        if (dut.fifo_count !== 3'd4 || imem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL full_state: count=%0d req=%b, required count=4 req=0", dut.fifo_count, imem_req);
        end
        base = mq[0];
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_cmp++;
            if (dut.fifo_count !== 3'(mq.size()) || out_pc !== base + 64'(4 * i) || out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL full_pop i=%0d: count=%0d pc=%h valid=%b, required count=%0d pc=%h valid=1",
                         i, dut.fifo_count, out_pc, out_valid, mq.size(), base + 64'(4 * i));
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 2) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF5;
            else redirect_pc = {$urandom, $urandom};
            #1;
            n_cmp++;
            if (out_valid !== m_valid() || imem_req !== m_req() || dut.fifo_count !== 3'(mq.size())) begin
                n_bad++;
                $display("FAIL rand_ctl c=%0d: valid=%b req=%b count=%0d, required valid=%b req=%b count=%0d",
                         c, out_valid, imem_req, dut.fifo_count, m_valid(), m_req(), mq.size());
            end
            if (m_req()) begin
                n_cmp++;
                if (imem_addr !== m_pc) begin
                    n_bad++;
                    $display("FAIL rand_addr c=%0d: addr=%h, required %h", c, imem_addr, m_pc);
                end
            end
            if (m_valid()) begin
                n_cmp++;
                if (out_pc !== mq[0] || out_instr !== m_instr(mq[0])) begin
                    n_bad++;
                    $display("FAIL rand_data c=%0d: pc=%h instr=%h, required pc=%h instr=%h",
                             c, out_pc, out_instr, mq[0], m_instr(mq[0]));
                end
            end
            tick();
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_steady();
        test_backpressure();
        test_redirect(64'h100, 1'b0);
        test_redirect(64'h103, 1'b0);
        test_redirect(64'h300, 1'b1);
        test_async_reset();
        test_full_pop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
